// File: rtl/windowed_reg_file.sv
// Windowed register file: overlapping register windows over a circular physical bank, spilling/filling the oldest window through a stream.
// Latency: reads are combinational from the current window; writes land on the rising edge; a spill or fill takes STRIDE accepted beats.
// Backpressure: spill_valid holds with stable spill_data until spill_ready; a fill advances only on fill_valid while fill_ready is high.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   reg_write, Rw, write_data   register write through the current window
//   Ri, Rj, read_data1/2        two combinational read ports
//   win_call, win_ret           advance / retreat the window pointer
//   cwp, busy                   current window pointer, spill/fill in progress
//   spill_valid/ready/data      outbound stream of the oldest resident window
//   fill_valid/ready/data       inbound stream restoring a spilled window
//   call_fault, ret_fault       one-cycle pulses on save-stack overflow/underflow
module windowed_reg_file #(
    parameter int DATA_W   = 16,
    parameter int NUM_WIN  = 4,
    parameter int WIN_REGS = 4,
    parameter int OVERLAP  = 2,
    parameter int SAVE_W   = 8,
    localparam int RA_W    = (WIN_REGS > 1) ? $clog2(WIN_REGS) : 1,
    localparam int CWP_W   = $clog2(NUM_WIN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write,
    input  logic [RA_W-1:0]   Rw,
    input  logic [DATA_W-1:0] write_data,
    input  logic [RA_W-1:0]   Ri,
    input  logic [RA_W-1:0]   Rj,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    input  logic              win_call,
    input  logic              win_ret,
    output logic [CWP_W-1:0]  cwp,
    output logic              busy,
    output logic              spill_valid,
    input  logic              spill_ready,
    output logic [DATA_W-1:0] spill_data,
    input  logic              fill_valid,
    output logic              fill_ready,
    input  logic [DATA_W-1:0] fill_data,
    output logic              call_fault,
    output logic              ret_fault
);

    localparam int STRIDE = WIN_REGS - OVERLAP;
    localparam int PHYS   = NUM_WIN * STRIDE;
    localparam int PIDX_W = (PHYS > 1) ? $clog2(PHYS) : 1;
    localparam int BEAT_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CWP_W-1:0]  CWP_ONE   = CWP_W'(1);
    localparam logic [CWP_W-1:0]  RES_MAX   = CWP_W'(NUM_WIN - 1);
    localparam logic [SAVE_W-1:0] SAVE_ONE  = SAVE_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(STRIDE - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, SPILL = 2'd1, FILL = 2'd2} state_t;

    state_t            state, state_nxt;
    logic [DATA_W-1:0] phys [PHYS];
    logic [CWP_W-1:0]  res;      // resident windows, 1..NUM_WIN-1
    logic [SAVE_W-1:0] saved;    // windows currently spilled out
    logic [BEAT_W-1:0] beat;

    // Window slot r of window w lives at (w*STRIDE + r) mod PHYS.
    function automatic logic [PIDX_W-1:0] pidx(input int win, input int r);
        return PIDX_W'((win * STRIDE + r) % PHYS);
    endfunction

    logic [CWP_W-1:0]  owp;        // oldest resident window (spill source)
    logic [CWP_W-1:0]  fill_win;   // window being restored
    logic [BEAT_W-1:0] fill_k;     // fill walks the slots in reverse spill order
    logic              do_call, do_ret, last_beat, spill_go, fill_go;

    assign owp       = cwp - res + CWP_ONE;
    assign fill_win  = cwp - CWP_ONE;
    assign fill_k    = BEAT_LAST - beat;
    assign last_beat = (beat == BEAT_LAST);
    // Simultaneous call and return cancel out.
    assign do_call   = (state == IDLE) && win_call && !win_ret;
    assign do_ret    = (state == IDLE) && win_ret && !win_call;
    assign spill_go  = (state == SPILL) && spill_ready;
    assign fill_go   = (state == FILL) && fill_valid;

    assign read_data1 = phys[pidx(int'(cwp), int'(Ri))];
    assign read_data2 = phys[pidx(int'(cwp), int'(Rj))];
    assign spill_data = phys[pidx(int'(owp), int'(beat))];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (do_call && (res == RES_MAX) && (saved != '1))
                    state_nxt = SPILL;
                else if (do_ret && (res == CWP_ONE) && (saved != '0))
                    state_nxt = FILL;
            end
            SPILL:   if (spill_go && last_beat) state_nxt = IDLE;
            FILL:    if (fill_go && last_beat)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy        = 1'b0;
        spill_valid = 1'b0;
        fill_ready  = 1'b0;
        case (state)
            SPILL: begin busy = 1'b1; spill_valid = 1'b1; end
            FILL:  begin busy = 1'b1; fill_ready  = 1'b1; end
            default: ;
        endcase
    end

    // Register bank, window bookkeeping and fault pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < PHYS; i++) phys[i] <= '0;
            cwp        <= '0;
            res        <= CWP_ONE;
            saved      <= '0;
            beat       <= '0;
            call_fault <= 1'b0;
            ret_fault  <= 1'b0;
        end else begin
            call_fault <= 1'b0;
            ret_fault  <= 1'b0;
            case (state)
                IDLE: begin
                    // Write uses the window in effect before any call/return this edge.
                    if (reg_write) phys[pidx(int'(cwp), int'(Rw))] <= write_data;
                    if (do_call) begin
                        if (res != RES_MAX) begin
                            cwp <= cwp + CWP_ONE;
                            res <= res + CWP_ONE;
                        end else if (saved == '1) begin
                            call_fault <= 1'b1;
                        end
                    end
                    if (do_ret) begin
                        if (res != CWP_ONE) begin
                            cwp <= cwp - CWP_ONE;
                            res <= res - CWP_ONE;
                        end else if (saved == '0) begin
                            ret_fault <= 1'b1;
                        end
                    end
                end
                SPILL: begin
                    if (spill_go) begin
                        if (last_beat) begin
                            beat  <= '0;
                            cwp   <= cwp + CWP_ONE;
                            saved <= saved + SAVE_ONE;
                        end else begin
                            beat <= beat + BEAT_ONE;
                        end
                    end
                end
                FILL: begin
                    if (fill_go) begin
                        phys[pidx(int'(fill_win), int'(fill_k))] <= fill_data;
                        if (last_beat) begin
                            beat  <= '0;
                            cwp   <= cwp - CWP_ONE;
                            saved <= saved - SAVE_ONE;
                        end else begin
                            beat <= beat + BEAT_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_windowed_reg_file.sv
// Directed vector bench for windowed_reg_file with default parameters.
// Each vector drives one cycle on the falling edge and checks outputs 1 time unit after the rising edge.
// Ends with an asynchronous reset asserted mid-spill and checked before the next clock edge.
module tb_windowed_reg_file;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [1:0]  Rw, Ri, Rj;
    logic [15:0] write_data, read_data1, read_data2;
    logic        win_call, win_ret;
    logic [1:0]  cwp;
    logic        busy;
    logic        spill_valid, spill_ready;
    logic [15:0] spill_data;
    logic        fill_valid, fill_ready;
    logic [15:0] fill_data;
    logic        call_fault, ret_fault;

    int n_vec  = 0;
    int n_miss = 0;

    windowed_reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .Rw         (Rw),
        .write_data (write_data),
        .Ri         (Ri),
        .Rj         (Rj),
        .read_data1 (read_data1),
        .read_data2 (read_data2),
        .win_call   (win_call),
        .win_ret    (win_ret),
        .cwp        (cwp),
        .busy       (busy),
        .spill_valid(spill_valid),
        .spill_ready(spill_ready),
        .spill_data (spill_data),
        .fill_valid (fill_valid),
        .fill_ready (fill_ready),
        .fill_data  (fill_data),
        .call_fault (call_fault),
        .ret_fault  (ret_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst, we;
        logic [1:0]  rw;
        logic [15:0] wd;
        logic [1:0]  ri, rj;
        logic        call, ret, srdy, fvld;
        logic [15:0] fd;
        logic [1:0]  e_cwp;
        logic        e_busy, e_sv;
        logic [15:0] e_sd;
        logic        e_fr, e_cf, e_rf;
        logic [15:0] e_rd1, e_rd2;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input int rst_i, we, rw, wd, ri, rj, call, ret, srdy, fvld, fd,
        input int e_cwp, e_busy, e_sv, e_sd, e_fr, e_cf, e_rf, e_rd1, e_rd2);
        vec_t m;
        m.rst  = 1'(rst_i); m.we = 1'(we); m.rw = 2'(rw); m.wd = 16'(wd);
        m.ri   = 2'(ri);    m.rj = 2'(rj);
        m.call = 1'(call);  m.ret = 1'(ret); m.srdy = 1'(srdy); m.fvld = 1'(fvld);
        m.fd   = 16'(fd);
        m.e_cwp = 2'(e_cwp); m.e_busy = 1'(e_busy); m.e_sv = 1'(e_sv);
        m.e_sd  = 16'(e_sd); m.e_fr = 1'(e_fr); m.e_cf = 1'(e_cf); m.e_rf = 1'(e_rf);
        m.e_rd1 = 16'(e_rd1); m.e_rd2 = 16'(e_rd2);
        return m;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s (vector %0d): got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; reg_write = v.we; Rw = v.rw; write_data = v.wd;
        Ri = v.ri; Rj = v.rj; win_call = v.call; win_ret = v.ret;
        spill_ready = v.srdy; fill_valid = v.fvld; fill_data = v.fd;
        @(posedge clk);
        #1;
        n_vec++;
        chk("cwp",         idx, cwp,         v.e_cwp);
        chk("busy",        idx, busy,        v.e_busy);
        chk("spill_valid", idx, spill_valid, v.e_sv);
        if (v.e_sv) chk("spill_data", idx, spill_data, v.e_sd);
        chk("fill_ready",  idx, fill_ready,  v.e_fr);
        chk("call_fault",  idx, call_fault,  v.e_cf);
        chk("ret_fault",   idx, ret_fault,   v.e_rf);
        chk("read_data1",  idx, read_data1,  v.e_rd1);
        chk("read_data2",  idx, read_data2,  v.e_rd2);
    endtask

    initial begin
        rst = 1'b1; reg_write = 1'b0; Rw = '0; write_data = '0; Ri = '0; Rj = '0;
        win_call = 1'b0; win_ret = 1'b0; spill_ready = 1'b0; fill_valid = 1'b0; fill_data = '0;

        //          rst we rw wd       ri rj cl rt sr fv fd        cwp bz sv sd       fr cf rf rd1      rd2
        // reset, return underflow fault, call+ret cancel
        vq.push_back(mk(1, 0, 0, 0,       0, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0,       0));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 1, 0, 0, 0,       0, 0, 0, 0,       0, 0, 1, 0,       0));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0,       0));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 1, 1, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0,       0));
        // overlap: R2 of window 0 is R0 of window 1
        vq.push_back(mk(0, 1, 2, 'h1234,  2, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 'h1234,  0));
        vq.push_back(mk(0, 0, 0, 0,       0, 2, 1, 0, 0, 0, 0,       1, 0, 0, 0,       0, 0, 0, 'h1234,  0));
        // reset clears bank, then load window 0
        vq.push_back(mk(1, 0, 0, 0,       0, 2, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0,       0));
        vq.push_back(mk(0, 1, 0, 'h1111,  0, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 'h1111,  0));
        vq.push_back(mk(0, 1, 1, 'h2222,  0, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 'h1111,  'h2222));
        vq.push_back(mk(0, 1, 2, 'h3333,  2, 3, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 'h3333,  0));
        vq.push_back(mk(0, 1, 3, 'h4444,  2, 3, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 'h3333,  'h4444));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 1, 0, 0, 0, 0,       1, 0, 0, 0,       0, 0, 0, 'h3333,  'h4444));
        // write in the same cycle as a call goes to the old window (phys5)
        vq.push_back(mk(0, 1, 3, 'h5555,  0, 1, 1, 0, 0, 0, 0,       2, 0, 0, 0,       0, 0, 0, 0,       'h5555));
        // third call spills window 0; ready held low for several cycles, writes/calls ignored
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 1, 0, 0, 0, 0,       2, 1, 1, 'h1111,  0, 0, 0, 0,       'h5555));
        vq.push_back(mk(0, 1, 0, 'hDEAD,  0, 1, 1, 0, 0, 0, 0,       2, 1, 1, 'h1111,  0, 0, 0, 0,       'h5555));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 0, 0, 0,       2, 1, 1, 'h1111,  0, 0, 0, 0,       'h5555));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 0, 0, 0,       2, 1, 1, 'h1111,  0, 0, 0, 0,       'h5555));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 1, 0, 0,       2, 1, 1, 'h2222,  0, 0, 0, 0,       'h5555));
        // last beat: cwp 3, whose R2/R3 wrap onto phys0/phys1
        vq.push_back(mk(0, 0, 0, 0,       2, 3, 0, 0, 1, 0, 0,       3, 0, 0, 0,       0, 0, 0, 'h1111,  'h2222));
        vq.push_back(mk(0, 1, 2, 'h5A5A,  2, 0, 0, 0, 0, 0, 0,       3, 0, 0, 0,       0, 0, 0, 'h5A5A,  0));
        // returns down to one resident window, third return fills window 0
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 1, 0, 0, 0,       2, 0, 0, 0,       0, 0, 0, 0,       'h5555));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 1, 0, 0, 0,       1, 0, 0, 0,       0, 0, 0, 'h3333,  'h4444));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 1, 0, 0, 0,       1, 1, 0, 0,       1, 0, 0, 'h3333,  'h4444));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 0, 0, 'hAAAA,  1, 1, 0, 0,       1, 0, 0, 'h3333,  'h4444));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 0, 1, 'hAAAA,  1, 1, 0, 0,       1, 0, 0, 'h3333,  'h4444));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 0, 0, 1, 'hBBBB,  0, 0, 0, 0,       0, 0, 0, 'hBBBB,  'hAAAA));
        // nothing left to fill: underflow fault pulse, then clear
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 0, 1, 0, 0, 0,       0, 0, 0, 0,       0, 0, 1, 'hBBBB,  'hAAAA));
        vq.push_back(mk(0, 0, 0, 0,       2, 3, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 'h3333,  'h4444));
        // setup for reset mid-spill
        vq.push_back(mk(1, 0, 0, 0,       0, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 0,       0));
        vq.push_back(mk(0, 1, 0, 'h0F0F,  0, 1, 0, 0, 0, 0, 0,       0, 0, 0, 0,       0, 0, 0, 'h0F0F,  0));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 1, 0, 0, 0, 0,       1, 0, 0, 0,       0, 0, 0, 0,       0));
        vq.push_back(mk(0, 0, 0, 0,       0, 1, 1, 0, 0, 0, 0,       2, 0, 0, 0,       0, 0, 0, 0,       0));
        vq.push_back(mk(0, 1, 0, 'h7777,  0, 2, 0, 0, 0, 0, 0,       2, 0, 0, 0,       0, 0, 0, 'h7777,  0));
        vq.push_back(mk(0, 0, 0, 0,       0, 2, 1, 0, 0, 0, 0,       2, 1, 1, 'h0F0F,  0, 0, 0, 'h7777,  0));
        vq.push_back(mk(0, 0, 0, 0,       0, 2, 0, 0, 1, 0, 0,       2, 1, 1, 0,       0, 0, 0, 'h7777,  0));

        for (int i = 0; i < vq.size(); i++) apply(vq[i], i);

        // One spill beat has been taken; reset between clock edges must act at once.
        #1;
        rst = 1'b1;
        #1;
        n_vec++;
        chk("async_rst spill_valid", -1, spill_valid, 1'b0);
        chk("async_rst busy",        -1, busy,        1'b0);
        chk("async_rst fill_ready",  -1, fill_ready,  1'b0);
        chk("async_rst cwp",         -1, cwp,         2'd0);
        chk("async_rst read_data1",  -1, read_data1,  16'h0000);
        chk("async_rst read_data2",  -1, read_data2,  16'h0000);

        @(negedge clk);
        rst = 1'b0;
        spill_ready = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        chk("post_rst busy", -2, busy, 1'b0);
        chk("post_rst cwp",  -2, cwp,  2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/windowed_reg_file.md
WINDOWED_REG_FILE -- requirements
Module: windowed_reg_file

Interface
REQ-001 Parameter DATA_W, 16, register data width.
REQ-002 Parameter NUM_WIN, 4, number of physical windows; power of 2, >=2.
REQ-003 Parameter WIN_REGS, 4, registers visible per window; power of 2.
REQ-004 Parameter OVERLAP, 2, registers shared between window w and w+1; 0 <= OVERLAP < WIN_REGS.
REQ-005 Parameter SAVE_W, 8, width of the spilled-window counter.
REQ-006 Derived: STRIDE = WIN_REGS-OVERLAP; PHYS = NUM_WIN*STRIDE; RA_W = log2(WIN_REGS); CWP_W = log2(NUM_WIN).
REQ-007 clk  in  1  single clock; all state updates on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 reg_write  in  1  write enable; Rw  in  RA_W  write address; write_data  in  DATA_W.
REQ-010 Ri, Rj  in  RA_W  read addresses; read_data1, read_data2  out  DATA_W  combinational read data.
REQ-011 win_call, win_ret  in  1  window advance / retreat requests.
REQ-012 cwp  out  CWP_W  current window pointer; busy  out  1  spill/fill in progress.
REQ-013 spill_valid  out  1; spill_ready  in  1; spill_data  out  DATA_W  spill stream.
REQ-014 fill_valid  in  1; fill_ready  out  1; fill_data  in  DATA_W  fill stream.
REQ-015 call_fault, ret_fault  out  1  one-cycle fault pulses.

Function
REQ-016 Logical register r maps to physical index (cwp*STRIDE + r) mod PHYS for read and write.
REQ-017 Reads are combinational from current cwp; a write lands on the rising edge, visible the following cycle; no bypass.
REQ-018 Internal state: cwp, res (resident windows, 1..NUM_WIN-1), saved (SAVE_W), state in {IDLE, SPILL, FILL}, beat counter.
REQ-019 In IDLE, reg_write writes write_data to Rw using the pre-edge cwp, including in a cycle also carrying win_call/win_ret.
REQ-020 win_call and win_ret asserted together in IDLE are a no-op.
REQ-021 win_call, res < NUM_WIN-1: cwp <= cwp+1 (mod NUM_WIN), res <= res+1, stay IDLE.
REQ-022 win_call, res == NUM_WIN-1, saved < max: enter SPILL of oldest window owp = (cwp-res+1) mod NUM_WIN.
REQ-023 SPILL: spill_valid=1, spill_data = phys[owp*STRIDE+k], k ascending 0..STRIDE-1; k advances on spill_valid&spill_ready.
REQ-024 On last spill beat: cwp <= cwp+1, saved <= saved+1, res unchanged, return to IDLE.
REQ-025 win_call, res == NUM_WIN-1, saved == 2^SAVE_W-1: call_fault pulses 1 cycle, no state change.
REQ-026 win_ret, res > 1: cwp <= cwp-1, res <= res-1, stay IDLE.
REQ-027 win_ret, res == 1, saved > 0: enter FILL of window f = cwp-1; fill_ready=1.
REQ-028 FILL: on fill_valid&fill_ready write fill_data to phys[f*STRIDE+k], k descending STRIDE-1..0 (LIFO of spill order).
REQ-029 On last fill beat: cwp <= cwp-1, saved <= saved-1, res stays 1, return to IDLE.
REQ-030 win_ret, res == 1, saved == 0: ret_fault pulses 1 cycle, no state change.
REQ-031 busy=1 exactly in SPILL/FILL; reg_write, win_call, win_ret ignored while busy; reads remain live.
REQ-032 spill_valid held with stable spill_data until accepted; spill_valid and fill_ready never both 1.

Reset
REQ-033 rst (any time, incl. mid-SPILL/FILL) immediately forces all PHYS registers 0, cwp=0, res=1, saved=0, state IDLE, beat counter 0.
REQ-034 During/after reset: busy, spill_valid, fill_ready, call_fault, ret_fault = 0; read_data = 0.

Verification (default parameters)
REQ-035 cwp=0, write Rw=2 0x1234, win_call -> cwp=1, read Ri=0 returns 0x1234 (overlap).
REQ-036 After reset, fill R0..R3 of window 0, 3x win_call -> third call: busy=1, spill beats phys0, phys1 in order; with spill_ready low 3 cycles data holds; then cwp=3, saved=1.
REQ-037 Continue REQ-036: 3x win_ret -> third ret enters FILL; supply 0xAAAA then 0xBBBB -> phys1=0xAAAA, phys0=0xBBBB, cwp=0, saved=0.
REQ-038 Directly after reset win_ret -> ret_fault=1 for one cycle, cwp=0; win_call+win_ret same cycle -> no change.
REQ-039 Assert rst mid-SPILL after one beat -> spill_valid=0, busy=0, cwp=0, all reads 0 same cycle.
REQ-040 cwp=3, write Rw=2 0x5A5A -> phys0=0x5A5A, visible from cwp=0 Ri=0 (wrap-around).
